// File: rtl/vector_add_stream_ctrl_pkg.sv
// rtl/vector_add_stream_ctrl_pkg.sv - shared constants and types for the vector add stream stage
//
// Purpose: lane geometry of the 16 x fp32 vector adder, its latency, the
// result FIFO depth, fp32 constants used by benches, and the controller
// state type.
package vector_add_stream_ctrl_pkg;

  localparam int LANES      = 16;
  localparam int FP_W       = 32;
  localparam int DATA_W     = LANES * FP_W;
  localparam int ADD_LAT    = 12;
  localparam int FIFO_DEPTH = 16;

  localparam logic [FP_W-1:0] FP32_ZERO  = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP32_ONE   = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP32_TWO   = 32'h4000_0000;
  localparam logic [FP_W-1:0] FP32_THREE = 32'h4040_0000;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Replicate one fp32 value into every lane of a vector.
  function automatic logic [DATA_W-1:0] splat_fp32(input logic [FP_W-1:0] v);
    return {LANES{v}};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO
//
// Purpose: result store for the vector add stage. The head word is always
// visible on pop_data while empty is low.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write strobe and word
//   pop                 advance past the head word
//   pop_data            head word
//   full, empty, count  occupancy status
module sync_fifo_fwft #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; a pop of an empty FIFO is ignored.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vector_add_stream_ctrl.sv
// rtl/vector_add_stream_ctrl.sv - credit-based flow control around the fixed-latency vector adder
//
// Purpose: issues operand pairs to the adder only when a result slot is
// reserved, captures every adder result into a FWFT FIFO and returns the
// results in issue order. After reset the stage waits long enough for any
// result issued before reset to leave the adder before accepting traffic.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_valid/s_ready             operand pair handshake
//   s_vec_a, s_vec_b            operands
//   add_in_valid, add_vec_a/b   registered issue to the adder
//   add_out_valid, add_out_vec  adder result
//   m_valid/m_ready, m_vec      result handshake and FIFO head
//   busy                        work outstanding or flushing
//   err                         sticky protocol error
module vector_add_stream_ctrl #(
  parameter int DATA_W     = vector_add_stream_ctrl_pkg::DATA_W,
  parameter int ADD_LAT    = vector_add_stream_ctrl_pkg::ADD_LAT,
  parameter int FIFO_DEPTH = vector_add_stream_ctrl_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_vec_a,
  input  logic [DATA_W-1:0] s_vec_b,
  output logic              add_in_valid,
  output logic [DATA_W-1:0] add_vec_a,
  output logic [DATA_W-1:0] add_vec_b,
  input  logic              add_out_valid,
  input  logic [DATA_W-1:0] add_out_vec,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_vec,
  output logic              busy,
  output logic              err
);

  import vector_add_stream_ctrl_pkg::*;

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int FCW = $clog2(ADD_LAT + 2);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(ADD_LAT + 1);

  state_t         state;
  state_t         state_next;
  logic [FCW-1:0] flush_cnt;
  logic [FCW-1:0] flush_cnt_next;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    credit_used;
  logic           fifo_full;
  logic           fifo_empty;
  logic           issue;
  logic           out_run;
  logic           retire;
  logic           capture;
  logic           pop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FLUSH;
      flush_cnt <= FLUSH_LOAD;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next state and handshake outputs. s_ready depends on registers only.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      ST_FLUSH: begin
        flush_cnt_next = flush_cnt - FCW'(1);
        if (flush_cnt == FCW'(1)) begin
          state_next = ST_RUN;
        end
      end
      default: ;
    endcase

    credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    s_ready     = (state == ST_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
    issue       = s_valid && s_ready;
    out_run     = add_out_valid && (state == ST_RUN);
    // Only results that match an outstanding issue are retired and stored;
    // anything else is a protocol violation and is discarded.
    retire      = out_run && (inflight != '0);
    capture     = retire && !fifo_full;
    m_valid     = !fifo_empty;
    pop         = m_valid && m_ready;
    busy        = (inflight != '0) || !fifo_empty || (state == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_in_valid <= 1'b0;
      add_vec_a    <= '0;
      add_vec_b    <= '0;
      inflight     <= '0;
      err          <= 1'b0;
    end else begin
      add_in_valid <= issue;
      if (issue) begin
        add_vec_a <= s_vec_a;
        add_vec_b <= s_vec_b;
      end
      case ({issue, retire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (out_run && ((inflight == '0) || fifo_full)) begin
        err <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (add_out_vec),
    .pop       (pop),
    .pop_data  (m_vec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/vector_add_stream_ctrl.md
Name: vector_add_stream_ctrl

Overview:
- Flow-control stage wrapped around the 16-lane fp32 vector adder (512-bit operands, fixed-latency adder IP, no backpressure).
- Upstream side: accepts operand pairs on a valid/ready stream and issues them to the adder only when result storage is guaranteed.
- Downstream side: captures every adder result into a local FIFO and presents results in order on a valid/ready stream.
- Sits between the MM partial-sum fetch logic and the result writeback path.

Parameters:
- DATA_W, 512, operand/result width (16 x fp32).
- ADD_LAT, 12, adder latency in cycles from input valid to output valid; must match the adder IP configuration.
- FIFO_DEPTH, 16, result FIFO entries (power of 2, >= ADD_LAT+2 for full throughput).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  stage can accept a pair this cycle.
- s_vec_a  in  DATA_W  operand A.
- s_vec_b  in  DATA_W  operand B.
- add_in_valid  out  1  to adder vector_input_valid.
- add_vec_a  out  DATA_W  to adder vector_1.
- add_vec_b  out  DATA_W  to adder vector_2.
- add_out_valid  in  1  from adder vector_output_valid.
- add_out_vec  in  DATA_W  from adder vector.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_vec  out  DATA_W  result (FIFO head).
- busy  out  1  inflight != 0 or FIFO non-empty or state == FLUSH.
- err  out  1  sticky protocol error.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: s_ready=0, add_in_valid=0, add_vec_a/b=0, m_valid=0, busy=1 (FLUSH), err=0, inflight=0, FIFO empty, state=FLUSH.
- States:
  - FLUSH: entered on rst. A down-counter loads ADD_LAT+1 and decrements each cycle. add_out_valid is ignored, which drains adder results issued before reset. At 0 go to RUN.
  - RUN: normal operation; leaves only on rst.
- Credit rule: s_ready = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH), computed from registers only, with no combinational path from s_valid or m_ready.
- Issue: on s_valid && s_ready, register operands into add_vec_a/b and set add_in_valid=1 for exactly one cycle (1-cycle issue latency). Otherwise add_in_valid=0; add_vec_a/b hold their last value.
- inflight:
  - +1 on issue; -1 on add_out_valid in RUN; both in the same cycle leave it unchanged.
  - Width clog2(FIFO_DEPTH)+1.
- Capture: add_out_valid in RUN pushes add_out_vec into the FIFO the same cycle.
- FIFO:
  - First-word-fall-through: m_valid = !empty, m_vec = head.
  - Pop on m_valid && m_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full (the credit rule keeps full+push impossible) and empty (a pushed word appears the next cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- End-to-end latency: s handshake to m_valid = 1 + ADD_LAT + 1 cycles.
- Ordering: results leave in strict issue order.
- err (sticky until rst):
  - set on add_out_valid in RUN with inflight==0, or
  - set on add_out_valid with FIFO full; in that case the word is dropped.
- Reset mid-operation clears the FIFO and inflight, discards all pending results and re-enters FLUSH; no stale result reaches m_vec.
- Backpressure: m_ready low indefinitely makes s_ready fall once inflight+fifo_count reaches FIFO_DEPTH; no result is ever lost.

Decomposition:
- Shared mm package holds the constants LANES=16, FP_W=32, DATA_W=LANES*FP_W, ADD_LAT, and the fp32 constants used by benches.
- One sub-module: sync_fifo_fwft (DATA_W, FIFO_DEPTH) with push, pop, full, empty and count.
- The credit/issue/flush logic stays in the top module.

Test Plan:
- Single op: after FLUSH, A = all lanes 0x3F800000 (1.0), B = all lanes 0x40000000 (2.0); bench adder model ADD_LAT=12 -> m_valid asserts exactly 14 cycles after handshake, m_vec all lanes 0x40400000 (3.0), err=0.
- Streaming: 64 back-to-back pairs with A lane i = i.0 and B = 1.0, m_ready=1 -> s_ready never drops after FLUSH; 64 in-order results, lane i = (i+1).0.
- Backpressure: m_ready=0, push continuously -> exactly 16 handshakes accepted, then s_ready=0. Raise m_ready -> all 16 drain in order, s_ready reasserts the cycle after inflight+count drops below 16.
- Reset mid-flight: issue 5 ops, assert rst 3 cycles later -> no m_valid during or after FLUSH from the stale ops; s_ready=0 for ADD_LAT+1 cycles, err=0.
- Spurious output: inject add_out_valid in RUN with inflight=0 -> err=1 and stays 1 until rst; FIFO count unchanged.
- Simultaneous push/pop at count 1 and at count FIFO_DEPTH-1 -> count is unchanged, data order is preserved.
